// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared definitions for the programmable clock divider.
//               Holds the controller state encoding and the default divisor
//               width / reset half-period.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int c_DIV_W      = 16;
    localparam int c_RESET_HALF = 60;   // 12 MHz -> 100 kHz

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_PEND = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RUN  = c_ST_RUN,
        PEND = c_ST_PEND
    } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_core
// Description : Half-period counter, output clock toggle flop and tick pulse.
//               While i_run is low everything is held at zero.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_run         - count and toggle when high
//               i_half        - active half-period (>= 1)
//               o_clkOut      - divided clock (registered)
//               o_tick        - one-cycle pulse with each o_clkOut rise
//               o_boundary    - period boundary (last count of high phase)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_core #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_half,
    output logic             o_clkOut,
    output logic             o_tick,
    output logic             o_boundary
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_clkOut;
    logic             r_tick;
    logic             w_lastCnt;

    // ">=" rather than "==" so a counter can never run past a half that
    // was changed underneath it; half is always >= 1 so no underflow.
    assign w_lastCnt  = (r_cnt >= (i_half - DIV_W'(1)));
    assign o_boundary = i_run & w_lastCnt & r_clkOut;
    assign o_clkOut   = r_clkOut;
    assign o_tick     = r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_clkOut <= 1'b0;
            r_tick   <= 1'b0;
        end else if (!i_run) begin
            r_cnt    <= '0;
            r_clkOut <= 1'b0;
            r_tick   <= 1'b0;
        end else if (w_lastCnt) begin
            r_cnt    <= '0;
            r_clkOut <= ~r_clkOut;
            // tick accompanies the 0->1 transition only
            r_tick   <= ~r_clkOut;
        end else begin
            r_cnt    <= r_cnt + DIV_W'(1);
            r_tick   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Programmable clock divider controller. Accepts a new
//               half-period through a valid/ready handshake and applies it
//               glitch-free at the next period boundary.
// Ports       : clock        - sole clock, rising edge
//               reset        - asynchronous active-high reset
//               io_en        - run request
//               io_divValid  - new half-period offered
//               io_divHalf   - requested half-period (0 is treated as 1)
//               io_divReady  - controller can accept a divisor
//               io_clkOut    - divided clock (registered)
//               io_tick      - pulse with each io_clkOut rise
//               io_curHalf   - active half-period   (CLK_DIV_CTRL_STATUS_EN)
//               io_pending   - divisor awaiting use (CLK_DIV_CTRL_STATUS_EN)
// Config      : define CLK_DIV_CTRL_STATUS_EN to add the status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W      = c_DIV_W,
    parameter int RESET_HALF = c_RESET_HALF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_divValid,
    input  logic [DIV_W-1:0] io_divHalf,
    output logic             io_divReady,
    output logic             io_clkOut,
    output logic             io_tick
`ifdef CLK_DIV_CTRL_STATUS_EN
    ,
    output logic [DIV_W-1:0] io_curHalf,
    output logic             io_pending
`endif
);

    localparam logic [DIV_W-1:0] c_RESET_HALF_W = DIV_W'(RESET_HALF);

    state_t           r_state;
    state_t           w_stateNext;
    logic [DIV_W-1:0] r_half;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] w_halfNext;
    logic [DIV_W-1:0] w_pendNext;
    logic [DIV_W-1:0] w_divClamped;
    logic             w_xfer;
    logic             w_run;
    logic             w_boundary;

    assign w_divClamped = (io_divHalf == '0) ? DIV_W'(1) : io_divHalf;
    assign io_divReady  = (r_state != PEND);
    assign w_xfer       = io_divValid & io_divReady;
    assign w_run        = (r_state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_half  <= c_RESET_HALF_W;
            r_pend  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_half  <= w_halfNext;
            r_pend  <= w_pendNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_halfNext  = r_half;
        w_pendNext  = r_pend;
        case (r_state)
            IDLE: begin
                // output is stopped, so a new divisor can take effect at once
                if (w_xfer) begin
                    w_halfNext = w_divClamped;
                end
                if (io_en) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                // A transfer wins over a stop request landing on the same
                // boundary: the divisor is parked and the stop is honoured
                // at the boundary where it gets applied.
                if (w_xfer) begin
                    w_pendNext  = w_divClamped;
                    w_stateNext = PEND;
                end else if (w_boundary && !io_en) begin
                    w_stateNext = IDLE;
                end
            end
            PEND: begin
                if (w_boundary) begin
                    w_halfNext  = r_pend;
                    w_stateNext = io_en ? RUN : IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk        (clock),
        .rst        (reset),
        .i_run      (w_run),
        .i_half     (r_half),
        .o_clkOut   (io_clkOut),
        .o_tick     (io_tick),
        .o_boundary (w_boundary)
    );

`ifdef CLK_DIV_CTRL_STATUS_EN
    assign io_curHalf = r_half;
    assign io_pending = (r_state == PEND);
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Self-checking bench for clk_div_ctrl. Expected io_tick cycle
//               numbers are queued by the stimulus; a monitor pops one on
//               every tick. Level checks are made directly by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int DIV_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             io_en;
    logic             io_divValid;
    logic [DIV_W-1:0] io_divHalf;
    logic             io_divReady;
    logic             io_clkOut;
    logic             io_tick;
`ifdef CLK_DIV_CTRL_STATUS_EN
    logic [DIV_W-1:0] io_curHalf;
    logic             io_pending;
`endif

    int nVec = 0;
    int nMis = 0;
    int cyc  = 0;
    int expQ[$];
    int expCyc;

    clk_div_ctrl #(
        .DIV_W      (DIV_W),
        .RESET_HALF (60)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_en       (io_en),
        .io_divValid (io_divValid),
        .io_divHalf  (io_divHalf),
        .io_divReady (io_divReady),
        .io_clkOut   (io_clkOut),
        .io_tick     (io_tick)
`ifdef CLK_DIV_CTRL_STATUS_EN
        ,
        .io_curHalf  (io_curHalf),
        .io_pending  (io_pending)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // Tick monitor: every pulse must match the next queued cycle number.
    always @(negedge clock) begin
        if (io_tick !== 1'b0) begin
            if (expQ.size() == 0) begin
                nVec++;
                nMis++;
                $display("FAIL tick: unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                expCyc = expQ.pop_front();
                chk("tick_cycle", cyc, expCyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int b;
        reset       = 1'b1;
        io_en       = 1'b0;
        io_divValid = 1'b0;
        io_divHalf  = '0;

        // ---- reset state ----
        @(negedge clock);
        chk("rst_clkOut", io_clkOut, 0);
        chk("rst_tick", io_tick, 0);
        chk("rst_ready", io_divReady, 1);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk("rst_curHalf", io_curHalf, 60);
        chk("rst_pending", io_pending, 0);
`endif
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_noEn_clkOut", io_clkOut, 0);

        // ---- default half 60: 120-cycle period ----
        io_en = 1'b1;
        e = cyc + 1;
        expQ.push_back(e + 60);
        expQ.push_back(e + 180);
        expQ.push_back(e + 300);
        waitUntil(e + 59);  chk("A_lowBeforeRise", io_clkOut, 0);
        waitUntil(e + 60);  chk("A_firstRise", io_clkOut, 1);
        waitUntil(e + 120); chk("A_fall", io_clkOut, 0);

        // ---- stop request at cnt 10 of high phase ----
        waitUntil(e + 310); io_en = 1'b0;
        waitUntil(e + 359); chk("B_highBeforeStop", io_clkOut, 1);
        waitUntil(e + 360); chk("B_stopFall", io_clkOut, 0);
        waitUntil(e + 430); chk("B_staysLow", io_clkOut, 0);

        // ---- divisor 5 offered while running ----
        io_en = 1'b1;
        e = cyc + 1;
        expQ.push_back(e + 60);
        waitUntil(e + 70); io_divValid = 1'b1; io_divHalf = 16'd5;
        waitUntil(e + 71); io_divValid = 1'b0;
        chk("C_readyDrop", io_divReady, 0);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk("C_pending", io_pending, 1);
`endif
        b = e + 120;
        waitUntil(b - 1);
        chk("C_readyBeforeBnd", io_divReady, 0);
        chk("C_highBeforeBnd", io_clkOut, 1);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk("C_curHalfOld", io_curHalf, 60);
`endif
        waitUntil(b);
        chk("C_readyBack", io_divReady, 1);
        chk("C_fallAtBnd", io_clkOut, 0);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk("C_curHalfNew", io_curHalf, 5);
        chk("C_pendingClr", io_pending, 0);
`endif
        // half 5 period 10; divisor 3 offered exactly on the b+10 boundary
        expQ.push_back(b + 5);
        expQ.push_back(b + 15);
        expQ.push_back(b + 23);
        expQ.push_back(b + 29);
        waitUntil(b + 9);  io_divValid = 1'b1; io_divHalf = 16'd3;
        waitUntil(b + 10); io_divValid = 1'b0;
        chk("C_simulPend", io_divReady, 0);
        chk("C_simulFall", io_clkOut, 0);
        waitUntil(b + 19); chk("C_oldRateHigh", io_clkOut, 1);
        waitUntil(b + 20); chk("C_simulApplied", io_divReady, 1);
        waitUntil(b + 30); io_en = 1'b0;
        waitUntil(b + 31); chk("C_highBeforeStop", io_clkOut, 1);
        waitUntil(b + 32); chk("C_stopFall", io_clkOut, 0);

        // ---- divisor 0 in IDLE clamps to 1: clock/2 ----
        waitUntil(b + 40);
        chk("D_readyIdle", io_divReady, 1);
        io_divValid = 1'b1; io_divHalf = 16'd0;
        @(negedge clock);
        io_divValid = 1'b0; io_en = 1'b1;
        chk("D_idleLow", io_clkOut, 0);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk("D_curHalfClamp", io_curHalf, 1);
`endif
        e = cyc + 1;
        for (int k = 0; k < 5; k++) expQ.push_back(e + 1 + 2 * k);
        waitUntil(e + 1); chk("D_toggle1", io_clkOut, 1);
        waitUntil(e + 2); chk("D_toggle0", io_clkOut, 0);
        waitUntil(e + 3); chk("D_toggle1b", io_clkOut, 1);
        waitUntil(e + 9); io_en = 1'b0;
        waitUntil(e + 12); chk("D_stopped", io_clkOut, 0);

        // ---- divisor 8 accepted, reset before it is applied ----
        waitUntil(e + 15);
        io_divValid = 1'b1; io_divHalf = 16'd20;
        @(negedge clock);
        io_divValid = 1'b0; io_en = 1'b1;
        e = cyc + 1;
        expQ.push_back(e + 20);
        waitUntil(e + 25); io_divValid = 1'b1; io_divHalf = 16'd8;
        waitUntil(e + 26); io_divValid = 1'b0;
        chk("E_readyDrop", io_divReady, 0);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk("E_pending", io_pending, 1);
`endif
        waitUntil(e + 30);
        chk("E_highBeforeRst", io_clkOut, 1);
        io_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("E_rstClkOut", io_clkOut, 0);
        chk("E_rstReady", io_divReady, 1);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk("E_rstCurHalf", io_curHalf, 60);
        chk("E_rstPending", io_pending, 0);
`endif
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("E_idleAfterRst", io_clkOut, 0);
        io_en = 1'b1;
        e = cyc + 1;
        expQ.push_back(e + 60);
        waitUntil(e + 59); chk("E_lowBeforeRise", io_clkOut, 0);
        waitUntil(e + 60); chk("E_rise60", io_clkOut, 1);
        waitUntil(e + 70); io_en = 1'b0;
        waitUntil(e + 120); chk("E_stopFall", io_clkOut, 0);
        waitUntil(e + 140);

        chk("ticks_outstanding", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
